// File: rtl/pkg_config.sv
// Shared core configuration: instruction width and the program-loader FSM encoding.
package pkg_config;

    localparam int INST_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } imem_loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into instruction words and writes them to
// consecutive word addresses of instruction memory, holding the core in reset until done.
module imem_loader
    import pkg_config::*;
#(
    parameter int MEM_SIZE   = 1024,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [INST_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  core_rst_o
);

    localparam logic [ADDR_WIDTH-1:0] LP_CAP_WORDS = ADDR_WIDTH'(MEM_SIZE / 4);

    imem_loader_state_t r_state;

    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [1:0]            r_idx;
    logic [INST_WIDTH-9:0] r_asm;

    logic                  r_byte_ready;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [INST_WIDTH-1:0] r_wr_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_core_rst;

    logic                  w_len_zero;
    logic                  w_len_over;
    logic                  w_byte_xfer;
    logic [ADDR_WIDTH-1:0] w_cnt_next;

    assign w_len_zero  = (len_i == '0);
    assign w_len_over  = (len_i > LP_CAP_WORDS);
    assign w_byte_xfer = byte_valid_i && r_byte_ready;
    assign w_cnt_next  = r_cnt + ADDR_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_asm        <= '0;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst   <= 1'b1;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                // A restart from DONE takes the same decision as a start from IDLE.
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        if (w_len_zero) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_err      <= 1'b0;
                            r_core_rst <= 1'b0;
                        end else if (w_len_over) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_err      <= 1'b1;
                            r_core_rst <= 1'b1;
                        end else begin
                            r_state      <= ST_COLLECT;
                            r_cnt        <= '0;
                            r_addr       <= '0;
                            r_idx        <= '0;
                            r_len        <= len_i;
                            r_byte_ready <= 1'b1;
                            r_busy       <= 1'b1;
                            r_done       <= 1'b0;
                            r_err        <= 1'b0;
                            r_core_rst   <= 1'b1;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (w_byte_xfer) begin
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_asm[7:0]   <= byte_i;
                            2'd1: r_asm[15:8]  <= byte_i;
                            2'd2: r_asm[23:16] <= byte_i;
                            default: begin
                                // Last byte goes straight into the write word.
                                r_state      <= ST_WRITE;
                                r_byte_ready <= 1'b0;
                                r_wr_en      <= 1'b1;
                                r_wr_addr    <= r_addr;
                                r_wr_data    <= {byte_i, r_asm};
                            end
                        endcase
                    end
                end

                ST_WRITE: begin
                    r_cnt  <= w_cnt_next;
                    r_addr <= r_addr + ADDR_WIDTH'(4);
                    if (w_cnt_next == r_len) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= 1'b0;
                        r_core_rst <= 1'b0;
                    end else begin
                        r_state      <= ST_COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready_o = r_byte_ready;
    assign wr_en_o      = r_wr_en;
    assign wr_addr_o    = r_wr_addr;
    assign wr_data_o    = r_wr_data;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign core_rst_o   = r_core_rst;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of image words plus hand-written load sequences.
module tb_imem_loader;
    import pkg_config::*;

    localparam int MEM_SIZE = 1024;
    localparam int AW       = 10;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           start_i;
    logic [AW-1:0]  len_i;
    logic [7:0]     byte_i;
    logic           byte_valid_i;
    logic           byte_ready_o;
    logic           wr_en_o;
    logic [AW-1:0]  wr_addr_o;
    logic [31:0]    wr_data_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;
    logic           core_rst_o;

    imem_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .core_rst_o(core_rst_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]    b0, b1, b2, b3;
        logic [31:0]   data;
    } vec_t;

    vec_t          img[4];
    logic [AW-1:0] cap_addr[$];
    logic [31:0]   cap_data[$];
    logic [31:0]   mem[MEM_SIZE/4];
    int            overlap = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    always @(negedge clk_i) begin
        if (wr_en_o) begin
            cap_addr.push_back(wr_addr_o);
            cap_data.push_back(wr_data_o);
            mem[wr_addr_o >> 2] = wr_data_o;
            if (byte_ready_o) overlap++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_byte_ready"}, byte_ready_o, 0);
        chk({tag, "_wr_en"},      wr_en_o, 0);
        chk({tag, "_wr_addr"},    wr_addr_o, 0);
        chk({tag, "_wr_data"},    wr_data_o, 0);
        chk({tag, "_busy"},       busy_o, 0);
        chk({tag, "_done"},       done_o, 0);
        chk({tag, "_err"},        err_o, 0);
        chk({tag, "_core_rst"},   core_rst_o, 1);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input int len);
        start_i = 1'b1;
        len_i   = AW'(len);
        tick();
        start_i = 1'b0;
    endtask

    // Offer one byte and wait until it is accepted; inputs change 1 time unit after the edge.
    task automatic send_byte(input logic [7:0] b);
        byte_i       = b;
        byte_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (byte_ready_o) begin
                tick();
                byte_valid_i = 1'b0;
                return;
            end
            tick();
        end
        byte_valid_i = 1'b0;
        chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic load_word(input int w, input bit toggle, input bit chk_lat);
        logic [7:0] bs[4];
        bs[0] = img[w % 4].b0;
        bs[1] = img[w % 4].b1;
        bs[2] = img[w % 4].b2;
        bs[3] = img[w % 4].b3;
        for (int k = 0; k < 4; k++) begin
            send_byte(bs[k]);
            if (k == 3 && chk_lat) begin
                chk("wr_en_after_4th_byte", wr_en_o, 1);
                chk("ready_low_in_write", byte_ready_o, 0);
            end
            if (toggle) tick();
        end
    endtask

    task automatic chk_image(input string tag, input int n);
        chk({tag, "_nwrites"}, cap_addr.size(), n);
        for (int i = 0; i < n && i < cap_addr.size(); i++) begin
            chk({tag, "_addr"}, cap_addr[i], i * 4);
            chk({tag, "_data"}, cap_data[i], img[i % 4].data);
            chk({tag, "_readback"}, mem[i], img[i % 4].data);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        img[0] = '{8'h13, 8'h81, 8'h10, 8'h00, 32'h00108113};
        img[1] = '{8'h93, 8'h81, 8'h10, 8'h00, 32'h00108193};
        img[2] = '{8'h33, 8'h02, 8'h31, 8'h00, 32'h00310233};
        img[3] = '{8'he3, 8'h8a, 8'h21, 8'hfe, 32'hfe218ae3};

        rst_i = 1'b1; start_i = 1'b0; len_i = '0; byte_i = '0; byte_valid_i = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst_i = 1'b0;
        tick();
        chk("idle_ready_low", byte_ready_o, 0);

        // Four-word image, valid held high.
        cap_addr.delete(); cap_data.delete();
        do_start(4);
        chk("ready_after_start", byte_ready_o, 1);
        chk("busy_after_start", busy_o, 1);
        chk("core_rst_loading", core_rst_o, 1);
        for (int w = 0; w < 4; w++) load_word(w, 1'b0, 1'b1);
        tick();
        chk("done_after_last_write", done_o, 1);
        chk("core_rst_released", core_rst_o, 0);
        chk("busy_cleared", busy_o, 0);
        chk("err_clear", err_o, 0);
        chk("wr_en_single", wr_en_o, 0);
        chk_image("img4", 4);

        // Same image restarted from DONE with valid toggling.
        cap_addr.delete(); cap_data.delete();
        overlap = 0;
        do_start(4);
        chk("restart_done_cleared", done_o, 0);
        chk("restart_core_rst", core_rst_o, 1);
        for (int w = 0; w < 4; w++) load_word(w, 1'b1, 1'b0);
        repeat (2) tick();
        chk("toggle_done", done_o, 1);
        chk("toggle_no_overlap", overlap, 0);
        chk_image("toggle", 4);

        // Zero length.
        cap_addr.delete(); cap_data.delete();
        do_start(0);
        chk("len0_done", done_o, 1);
        chk("len0_err", err_o, 0);
        chk("len0_core_rst", core_rst_o, 0);
        chk("len0_busy", busy_o, 0);
        repeat (5) tick();
        chk("len0_no_writes", cap_addr.size(), 0);

        // Over capacity.
        do_start(257);
        chk("len257_done", done_o, 1);
        chk("len257_err", err_o, 1);
        chk("len257_core_rst", core_rst_o, 1);
        repeat (5) tick();
        chk("len257_core_rst_held", core_rst_o, 1);
        chk("len257_no_writes", cap_addr.size(), 0);

        // Full memory: last word lands at MEM_SIZE-4.
        cap_addr.delete(); cap_data.delete();
        do_start(256);
        for (int w = 0; w < 256; w++) load_word(w, 1'b0, 1'b0);
        tick();
        chk("full_done", done_o, 1);
        chk("full_err", err_o, 0);
        chk("full_nwrites", cap_addr.size(), 256);
        if (cap_addr.size() == 256) begin
            chk("full_last_addr", cap_addr[255], 10'h3fc);
            chk("full_last_data", cap_data[255], 32'hfe218ae3);
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (cap_addr[i] !== AW'(i * 4) || cap_data[i] !== img[i % 4].data) bad++;
            chk("full_seq_errors", bad, 0);
        end

        // Reset after two bytes, then a fresh one-word load.
        cap_addr.delete(); cap_data.delete();
        do_start(2);
        send_byte(8'haa);
        send_byte(8'hbb);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk_reset_vals("midrst");
        chk("midrst_no_writes", cap_addr.size(), 0);
        do_start(1);
        load_word(0, 1'b0, 1'b1);
        tick();
        chk("midrst_done", done_o, 1);
        chk("midrst_core_rst", core_rst_o, 0);
        chk("midrst_nwrites", cap_addr.size(), 1);
        if (cap_addr.size() >= 1) begin
            chk("midrst_addr", cap_addr[0], 0);
            chk("midrst_data", cap_data[0], 32'h00108113);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
